// File: rtl/lx_secure_bypass_arbiter_pkg.sv
// lx_secure_bypass_arbiter_pkg: message codes, FSM states and helpers for the secure L2 bypass
package lx_secure_bypass_arbiter_pkg;
  localparam int NO_REQ    = 0;
  localparam int R_REQ     = 1;
  localparam int WB_REQ    = 2;
  localparam int MEM_RESP  = 3;
  localparam int MEM_READY = 4;
  typedef enum logic [2:0] {S_IDLE, S_MEM_RD, S_MEM_WR, S_RESP, S_SCRUB} state_t;
  function automatic int next_port(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/lx_secure_bypass_arbiter_rr_arbiter.sv
// lx_secure_bypass_arbiter_rr_arbiter: combinational round-robin pick starting at ptr
module lx_secure_bypass_arbiter_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // walk from the farthest offset back to ptr so the closest requester overwrites last
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/lx_secure_bypass_arbiter.sv
// lx_secure_bypass_arbiter: serialises round-robin line requests into word transactions on one memory port
module lx_secure_bypass_arbiter
  import lx_secure_bypass_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int OFFSET_BITS   = 2,
  parameter int MSG_BITS      = 3,
  parameter int SCRUB_EN      = 1,
  localparam int WPL    = 1 << OFFSET_BITS,
  localparam int LINE_W = DATA_WIDTH * WPL,
  localparam int GW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]     msg_in,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] address,
  input  logic [NUM_PORTS*LINE_W-1:0]       data_in,
  output logic [NUM_PORTS*MSG_BITS-1:0]     msg_out,
  output logic [NUM_PORTS*ADDRESS_WIDTH-1:0] out_address,
  output logic [NUM_PORTS*LINE_W-1:0]       data_out,
  output logic [MSG_BITS-1:0]               lxb2mm_msg,
  output logic [ADDRESS_WIDTH-1:0]          lxb2mm_address,
  output logic [DATA_WIDTH-1:0]             lxb2mm_data,
  input  logic [MSG_BITS-1:0]               mm2lxb_msg,
  input  logic [ADDRESS_WIDTH-1:0]          mm2lxb_address,
  input  logic [DATA_WIDTH-1:0]             mm2lxb_data,
  output logic                              busy,
  output logic [GW-1:0]                     grant_id
);
  localparam logic [MSG_BITS-1:0] M_NO    = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] M_R     = MSG_BITS'(R_REQ);
  localparam logic [MSG_BITS-1:0] M_WB    = MSG_BITS'(WB_REQ);
  localparam logic [MSG_BITS-1:0] M_RESP  = MSG_BITS'(MEM_RESP);
  localparam logic [MSG_BITS-1:0] M_READY = MSG_BITS'(MEM_READY);

  state_t                     state_q, state_d;
  logic [GW-1:0]              rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic                       rd_q, rd_d;
  logic [ADDRESS_WIDTH-1:0]   line_q, line_d;
  logic [OFFSET_BITS-1:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0]          buf_q, buf_d;
  logic [MSG_BITS-1:0]        mm_msg_q, mm_msg_d;
  logic [ADDRESS_WIDTH-1:0]   mm_addr_q, mm_addr_d;
  logic [DATA_WIDTH-1:0]      mm_data_q, mm_data_d;

  logic [NUM_PORTS-1:0]       req, gnt;
  logic [GW-1:0]              gidx;
  logic [MSG_BITS-1:0]        sel_msg, g_msg;
  logic [OFFSET_BITS-1:0]     nxt;
  logic                       last, acc, take;

  // a port competes only with a read or writeback request
  always_comb begin
    req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p] = (msg_in[p*MSG_BITS +: MSG_BITS] == M_R) || (msg_in[p*MSG_BITS +: MSG_BITS] == M_WB);
    end
  end

  lx_secure_bypass_arbiter_rr_arbiter #(.N(NUM_PORTS), .IW(GW)) u_rr (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gidx)
  );

  assign sel_msg = msg_in[int'(gidx)*MSG_BITS +: MSG_BITS];
  assign g_msg   = msg_in[int'(grant_q)*MSG_BITS +: MSG_BITS];
  assign take    = (state_q == S_IDLE) && (|gnt);
  assign nxt     = cnt_q + 1'b1;
  assign last    = &cnt_q;
  assign acc     = ((state_q == S_MEM_RD && mm2lxb_msg == M_RESP) ||
                    (state_q == S_MEM_WR && mm2lxb_msg == M_READY)) &&
                   (mm2lxb_address == {line_q[ADDRESS_WIDTH-1:OFFSET_BITS], cnt_q});

  // all state; reset aborts any transaction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      rd_q      <= 1'b0;
      line_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      mm_msg_q  <= '0;
      mm_addr_q <= '0;
      mm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      rd_q      <= rd_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      mm_msg_q  <= mm_msg_d;
      mm_addr_q <= mm_addr_d;
      mm_data_q <= mm_data_d;
    end
  end

  // next state: memory phases ignore withdrawal, RESP waits for the requester to drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:             if (take) state_d = (sel_msg == M_R) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD, S_MEM_WR: if (acc && last) state_d = S_RESP;
      S_RESP:             if (g_msg == M_NO) state_d = (SCRUB_EN != 0) ? S_SCRUB : S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // grant capture, word counter, line buffer and the registered memory request
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    rd_d      = rd_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    mm_msg_d  = mm_msg_q;
    mm_addr_d = mm_addr_q;
    mm_data_d = mm_data_q;
    if (take) begin
      grant_d   = gidx;
      rr_ptr_d  = GW'(next_port(int'(gidx), NUM_PORTS));
      rd_d      = sel_msg == M_R;
      line_d    = {address[int'(gidx)*ADDRESS_WIDTH+OFFSET_BITS +: ADDRESS_WIDTH-OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      cnt_d     = '0;
      buf_d     = rd_d ? buf_q : data_in[int'(gidx)*LINE_W +: LINE_W];
      mm_msg_d  = rd_d ? M_R : M_WB;
      mm_addr_d = line_d;
      mm_data_d = rd_d ? '0 : data_in[int'(gidx)*LINE_W +: DATA_WIDTH];
    end
    if (acc) begin
      cnt_d = nxt;
      if (state_q == S_MEM_RD) buf_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = mm2lxb_data;
      mm_msg_d  = last ? M_NO : mm_msg_q;
      mm_addr_d = last ? '0 : {line_q[ADDRESS_WIDTH-1:OFFSET_BITS], nxt};
      mm_data_d = (last || state_q == S_MEM_RD) ? '0 : buf_q[int'(nxt)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (state_q == S_SCRUB) buf_d = '0;
  end

  // responses reach only the granted port and only while in RESP
  always_comb begin
    msg_out     = '0;
    out_address = '0;
    data_out    = '0;
    if (state_q == S_RESP) begin
      msg_out[int'(grant_q)*MSG_BITS +: MSG_BITS]               = rd_q ? M_RESP : M_READY;
      out_address[int'(grant_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH] = line_q;
      data_out[int'(grant_q)*LINE_W +: LINE_W]                  = buf_q;
    end
  end

  assign busy           = state_q != S_IDLE;
  assign grant_id       = grant_q;
  assign lxb2mm_msg     = mm_msg_q;
  assign lxb2mm_address = mm_addr_q;
  assign lxb2mm_data    = mm_data_q;
endmodule

// File: tb/tb_lx_secure_bypass_arbiter.sv
// tb_lx_secure_bypass_arbiter: directed vectors against a zero-wait memory model
module tb_lx_secure_bypass_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [5:0]   msg_in = '0;
  logic [63:0]  address = '0;
  logic [255:0] data_in = '0;
  logic [5:0]   msg_out;
  logic [63:0]  out_address;
  logic [255:0] data_out;
  logic [2:0]   lxb2mm_msg;
  logic [31:0]  lxb2mm_address, lxb2mm_data;
  logic [2:0]   mm2lxb_msg;
  logic [31:0]  mm2lxb_address, mm2lxb_data;
  logic         busy;
  logic [0:0]   grant_id;
  logic         stray = 1'b0;
  logic [63:0]  wr_q[$];
  int           n_vec = 0;
  int           n_bad = 0;

  localparam logic [127:0] RD_LINE = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] L0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] L1 = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
  localparam logic [127:0] LB = {4{32'hDEADBEEF}};

  lx_secure_bypass_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .msg_in         (msg_in),
    .address        (address),
    .data_in        (data_in),
    .msg_out        (msg_out),
    .out_address    (out_address),
    .data_out       (data_out),
    .lxb2mm_msg     (lxb2mm_msg),
    .lxb2mm_address (lxb2mm_address),
    .lxb2mm_data    (lxb2mm_data),
    .mm2lxb_msg     (mm2lxb_msg),
    .mm2lxb_address (mm2lxb_address),
    .mm2lxb_data    (mm2lxb_data),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  always #5 clock = ~clock;

  // memory answers in the same cycle; reads return 0xA0 + word offset
  always_comb begin
    mm2lxb_msg     = 3'd0;
    mm2lxb_address = '0;
    mm2lxb_data    = '0;
    if (stray) begin
      mm2lxb_msg     = 3'd3;
      mm2lxb_address = 32'h99;
      mm2lxb_data    = 32'hBAD;
    end else if (lxb2mm_msg == 3'd1) begin
      mm2lxb_msg     = 3'd3;
      mm2lxb_address = lxb2mm_address;
      mm2lxb_data    = 32'hA0 + {30'd0, lxb2mm_address[1:0]};
    end else if (lxb2mm_msg == 3'd2) begin
      mm2lxb_msg     = 3'd4;
      mm2lxb_address = lxb2mm_address;
    end
  end

  // log every accepted write word
  always @(posedge clock) if (lxb2mm_msg == 3'd2 && mm2lxb_msg == 3'd4) wr_q.push_back({lxb2mm_address, lxb2mm_data});

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input int p, input logic [2:0] m, input logic [31:0] a, input logic [127:0] d);
    msg_in[p*3 +: 3]    = m;
    address[p*32 +: 32] = a;
    data_in[p*128 +: 128] = d;
  endtask

  task automatic serve(input int p, input logic [2:0] code, input logic [31:0] a, input string tag);
    int n = 0;
    while (msg_out[p*3 +: 3] != code && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_msg"}, msg_out[p*3 +: 3], code);
    chk({tag, "_gid"}, grant_id, p[0]);
    chk({tag, "_addr"}, out_address[p*32 +: 32], a);
    msg_in[p*3 +: 3] = 3'd0;
    @(negedge clock);
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] base, input logic [127:0] line);
    chk({tag, "_n"}, wr_q.size(), 4);
    for (int i = 0; i < wr_q.size() && i < 4; i++) begin
      chk({tag, "_wa"}, wr_q[i][63:32], base + i);
      chk({tag, "_wd"}, wr_q[i][31:0], line[i*32 +: 32]);
    end
    wr_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_mm", {lxb2mm_msg, lxb2mm_address, lxb2mm_data}, 0);
    chk("rst_out", {msg_out, out_address}, 0);
    reset = 1'b1;
    @(negedge clock);
    // read at 0x40, exact latency
    req(0, 3'd1, 32'h40, '0);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      chk("rd_mmmsg", lxb2mm_msg, 3'd1);
      chk("rd_mmaddr", lxb2mm_address, 32'h40 + i);
      chk("rd_noresp", msg_out, 0);
      @(negedge clock);
    end
    chk("rd_resp", msg_out[2:0], 3'd3);
    chk("rd_line", data_out[127:0], RD_LINE);
    chk("rd_oaddr", out_address[31:0], 32'h40);
    chk("rd_mmidle", lxb2mm_msg, 0);
    chk("rd_other", {msg_out[5:3], out_address[63:32], data_out[255:128]}, 0);
    msg_in[2:0] = 3'd0;
    @(negedge clock);
    chk("scrub_busy", busy, 1);
    chk("scrub_data", data_out, 0);
    chk("scrub_msg", msg_out, 0);
    @(negedge clock);
    chk("idle_busy", busy, 0);
    // port1 read with a stray response in the first word
    req(1, 3'd1, 32'h102, '0);
    @(negedge clock);
    chk("st_gid", grant_id, 1);
    chk("st_addr0", lxb2mm_address, 32'h100);
    stray = 1'b1;
    @(negedge clock);
    chk("st_hold", lxb2mm_address, 32'h100);
    stray = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      chk("st_addr", lxb2mm_address, 32'h100 + i);
    end
    @(negedge clock);
    chk("st_resp", msg_out[5:3], 3'd3);
    chk("st_line", data_out[255:128], RD_LINE);
    chk("st_oaddr", out_address[63:32], 32'h100);
    chk("st_p0", {msg_out[2:0], data_out[127:0]}, 0);
    msg_in[5:3] = 3'd0;
    repeat (2) @(negedge clock);
    // simultaneous writebacks with ptr at 0
    wr_q.delete();
    req(0, 3'd2, 32'h200, L0);
    req(1, 3'd2, 32'h300, L1);
    @(negedge clock);
    chk("pr_gid", grant_id, 0);
    chk("pr_mm", {lxb2mm_msg, lxb2mm_address, lxb2mm_data}, {3'd2, 32'h200, 32'h11111111});
    serve(0, 3'd4, 32'h200, "pr0");
    chk_wr("pr0", 32'h200, L0);
    serve(1, 3'd4, 32'h300, "pr1");
    chk_wr("pr1", 32'h300, L1);
    @(negedge clock);
    req(0, 3'd1, 32'h40, '0);
    req(1, 3'd1, 32'h300, '0);
    @(negedge clock);
    chk("pr2_gid", grant_id, 0);
    serve(0, 3'd3, 32'h40, "pr2a");
    serve(1, 3'd3, 32'h300, "pr2b");
    @(negedge clock);
    // port1 writeback of a constant line
    wr_q.delete();
    req(1, 3'd2, 32'h80, LB);
    @(negedge clock);
    chk("wb_gid", grant_id, 1);
    serve(1, 3'd4, 32'h80, "wb");
    chk_wr("wb", 32'h80, LB);
    @(negedge clock);
    // withdrawal during the read phase
    req(0, 3'd1, 32'h44, '0);
    @(negedge clock);
    chk("wd_busy", busy, 1);
    msg_in[2:0] = 3'd0;
    repeat (4) @(negedge clock);
    chk("wd_resp", msg_out[2:0], 3'd3);
    chk("wd_line", data_out[127:0], RD_LINE);
    @(negedge clock);
    chk("wd_onecyc", msg_out, 0);
    chk("wd_scrub", data_out, 0);
    @(negedge clock);
    chk("wd_idle", busy, 0);
    // simultaneous writebacks with ptr at 1
    wr_q.delete();
    req(0, 3'd2, 32'h200, L1);
    req(1, 3'd2, 32'h300, L0);
    @(negedge clock);
    chk("p1_gid", grant_id, 1);
    serve(1, 3'd4, 32'h300, "p1a");
    chk_wr("p1a", 32'h300, L0);
    serve(0, 3'd4, 32'h200, "p1b");
    chk_wr("p1b", 32'h200, L1);
    @(negedge clock);
    // reset in the middle of a read
    req(1, 3'd1, 32'h40, '0);
    repeat (2) @(negedge clock);
    chk("ar_gid1", grant_id, 1);
    reset = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_gid", grant_id, 0);
    chk("ar_mm", {lxb2mm_msg, lxb2mm_address, lxb2mm_data}, 0);
    chk("ar_out", {msg_out, out_address}, 0);
    chk("ar_data", data_out, 0);
    msg_in = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("ar_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
